// File: rtl/regfile_init.sv
// regfile_init: two-read / one-write register file that clears itself after
// reset. While the array is being swept to zero the pipeline is stalled and
// every read returns 0. Register 0 is hard-wired to zero.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write-back
// data to a read port addressing the register being written.
`timescale 1ns/1ps
module regfile_init #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [4:0]        raddr1,
  input  logic              re2,
  input  logic [4:0]        raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              stallreq,
  output logic              init_done
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e            state_q;
  logic [4:0]        cnt_q;
  logic [4:0]        cnt_d;
  logic              stallreq_q;
  logic              initDone_q;
  logic [DATA_W-1:0] regs_q [REG_NUM];

  logic              wrEn;
  logic [4:0]        wrAddr;
  logic [DATA_W-1:0] wrData;

  // The sweep counter simply rolls over, so it is back at 0 when RUN starts.
  assign cnt_d = cnt_q + 5'd1;

  // Sequencer: sweep all 32 addresses once after reset, then stay in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      cnt_q      <= 5'd0;
      stallreq_q <= 1'b1;
      initDone_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= cnt_d;
          if (cnt_q == 5'd31) begin
            state_q    <= RUN;
            stallreq_q <= 1'b0;
            initDone_q <= 1'b1;
          end
        end
        RUN: begin
          state_q    <= RUN;
          stallreq_q <= 1'b0;
          initDone_q <= 1'b1;
        end
        default: begin
          state_q    <= INIT;
          cnt_q      <= 5'd0;
          stallreq_q <= 1'b1;
          initDone_q <= 1'b0;
        end
      endcase
    end
  end

  // Single array write port: the clearing sweep owns it in INIT, write-back in RUN.
  always_comb begin
    wrEn   = 1'b0;
    wrAddr = cnt_q;
    wrData = '0;
    if (state_q == INIT) begin
      wrEn   = 1'b1;
      wrAddr = cnt_q;
      wrData = '0;
    end else begin
      wrEn   = we && (waddr != 5'd0);
      wrAddr = waddr;
      wrData = wdata;
    end
  end

  // Storage array carries no reset; its contents are defined by the INIT sweep.
  always_ff @(posedge clk) begin
    if (wrEn && (int'(wrAddr) < REG_NUM)) begin
      regs_q[wrAddr] <= wrData;
    end
  end

  // Read port 1: disabled, INIT and register 0 all yield zero.
  always_comb begin
    rdata1 = '0;
    if (re1 && (state_q == RUN) && (raddr1 != 5'd0)) begin
`ifdef REGFILE_BYPASS_EN
      if (we && (waddr == raddr1)) begin
        rdata1 = wdata;
      end else if (int'(raddr1) < REG_NUM) begin
        rdata1 = regs_q[raddr1];
      end
`else
      if (int'(raddr1) < REG_NUM) begin
        rdata1 = regs_q[raddr1];
      end
`endif
    end
  end

  // Read port 2: identical rules, fully independent of port 1.
  always_comb begin
    rdata2 = '0;
    if (re2 && (state_q == RUN) && (raddr2 != 5'd0)) begin
`ifdef REGFILE_BYPASS_EN
      if (we && (waddr == raddr2)) begin
        rdata2 = wdata;
      end else if (int'(raddr2) < REG_NUM) begin
        rdata2 = regs_q[raddr2];
      end
`else
      if (int'(raddr2) < REG_NUM) begin
        rdata2 = regs_q[raddr2];
      end
`endif
    end
  end

  assign stallreq  = stallreq_q;
  assign init_done = initDone_q;

endmodule
